// File: rtl/fm_sb_pkg.sv
// Shared fast-monitoring spy-buffer types: the fm_rt stream, the playback modes
// and the word-width helper used by both capture and playback ends.
package fm_sb_pkg;

    localparam int mon_dw_max       = 256;
    localparam int PB_DEPTH_DEFAULT = 512;

    typedef struct packed {
        logic [mon_dw_max-1:0] fm_data;
        logic                  fm_vld;
    } fm_rt;

    typedef enum logic [1:0] {
        PB_OFF  = 2'b00,
        PB_ONCE = 2'b01,
        PB_LOOP = 2'b10,
        PB_RSVD = 2'b11
    } pb_mode_t;

    // Round a requested width up to the nearest legal spy-buffer word width.
    function automatic int find_sb_dw(input int dw);
        if (dw <= 32) begin
            return 32;
        end else if (dw <= 64) begin
            return 64;
        end else if (dw <= 128) begin
            return 128;
        end else begin
            return 256;
        end
    endfunction

endpackage

// File: rtl/fm_sb_pb_ram.sv
// Playback pattern store: one write port, one read port with a registered,
// enable-gated output so the last read word is held between reads.
module fm_sb_pb_ram #(
    parameter int DW    = 256,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];
    logic [DW-1:0] rdata_r;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Registered read port, holds its value when no read is issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_r <= {DW{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[raddr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/fm_sb_playback.sv
// Spy-buffer playback: packs AXI write beats into SB_DW words, then replays them
// as an fm_rt stream, single pass or looping, with hold and sticky error flags.
module fm_sb_playback
    import fm_sb_pkg::*;
#(
    parameter int SB_DW     = 256,
    parameter int AXI_DW    = 32,
    parameter int DEPTH     = PB_DEPTH_DEFAULT,
    parameter int PB_MODE_W = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [PB_MODE_W-1:0]  pb_mode,
    input  logic                  pb_start,
    input  logic                  pb_hold,
    input  logic                  wr_clr,
    input  logic                  wr_en,
    input  logic [AXI_DW-1:0]     wr_data,
    output logic                  wr_ready,
    output logic [$clog2(DEPTH):0] wr_count,
    output fm_rt                  fm_o,
    output logic                  pb_busy,
    output logic                  pb_done,
    output logic [2:0]            err_o
);

    localparam int BEATS = SB_DW / AXI_DW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } pb_state_t;

    pb_state_t      state_r, state_s;
    pb_mode_t       mode_s;
    logic [BW-1:0]  beat_r;
    logic [SB_DW-1:0] word_r, word_s, rd_data_s;
    logic [CW-1:0]  wr_count_r;
    logic [AW-1:0]  rd_addr_r;
    logic [2:0]     err_r, err_set_s;
    logic           fm_vld_r, pb_done_r;
    logic           wr_ready_s, accept_s, commit_s, mode_ok_s, issue_s, last_s;

    assign mode_s     = pb_mode_t'(pb_mode[1:0]);
    assign mode_ok_s  = (mode_s == PB_ONCE) || (mode_s == PB_LOOP);
    assign wr_ready_s = (state_r == ST_IDLE) && (wr_count_r < CW'(DEPTH));
    assign accept_s   = wr_en && wr_ready_s && !wr_clr;
    assign commit_s   = accept_s && (beat_r == BW'(BEATS - 1));
    assign issue_s    = (state_r == ST_RUN) && mode_ok_s && !pb_hold && (wr_count_r != CW'(0));
    assign last_s     = issue_s && ({1'b0, rd_addr_r} == (wr_count_r - CW'(1)));

    // Merge the incoming beat into the partial word so the last beat commits in one step.
    always_comb begin
        word_s = word_r;
        word_s[beat_r*AXI_DW +: AXI_DW] = wr_data;
    end

    // Sticky error sources; a reserved mode is flagged on start or while running.
    always_comb begin
        err_set_s    = 3'b000;
        err_set_s[0] = wr_en && !wr_ready_s;
        err_set_s[1] = pb_start && (state_r == ST_IDLE) && (wr_count_r == CW'(0));
        err_set_s[2] = (mode_s == PB_RSVD) &&
                       (((state_r == ST_IDLE) && pb_start) || (state_r == ST_RUN));
    end

    // Next-state: leave RUN on an invalid mode, an emptied store, or single-pass wrap.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pb_start && mode_ok_s && (wr_count_r != CW'(0))) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (!mode_ok_s || (wr_count_r == CW'(0))) begin
                    state_s = ST_IDLE;
                end else if (last_s && (mode_s == PB_ONCE)) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Playback state, read pointer and the valid/done flags aligned with RAM output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            rd_addr_r <= AW'(0);
            fm_vld_r  <= 1'b0;
            pb_done_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            fm_vld_r  <= issue_s;
            pb_done_r <= last_s && (mode_s == PB_ONCE);
            if (state_r != ST_RUN) begin
                rd_addr_r <= AW'(0);
            end else if (issue_s) begin
                rd_addr_r <= last_s ? AW'(0) : (rd_addr_r + AW'(1));
            end else begin
                rd_addr_r <= rd_addr_r;
            end
        end
    end

    // Beat packer, stored-word count and sticky errors; wr_clr beats a same-cycle write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_r     <= BW'(0);
            word_r     <= {SB_DW{1'b0}};
            wr_count_r <= CW'(0);
            err_r      <= 3'b000;
        end else if (wr_clr) begin
            beat_r     <= BW'(0);
            wr_count_r <= CW'(0);
            err_r      <= 3'b000;
        end else begin
            err_r <= err_r | err_set_s;
            if (accept_s) begin
                word_r <= word_s;
                beat_r <= commit_s ? BW'(0) : (beat_r + BW'(1));
            end
            if (commit_s) begin
                wr_count_r <= wr_count_r + CW'(1);
            end
        end
    end

    fm_sb_pb_ram #(
        .DW    (SB_DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (commit_s),
        .waddr (wr_count_r[AW-1:0]),
        .wdata (word_s),
        .re    (issue_s),
        .raddr (rd_addr_r),
        .rdata (rd_data_s)
    );

    // Zero-extend the replayed word onto the monitor-width stream.
    always_comb begin
        fm_o.fm_data              = {mon_dw_max{1'b0}};
        fm_o.fm_data[SB_DW-1:0]   = rd_data_s;
        fm_o.fm_vld               = fm_vld_r;
    end

    assign wr_ready = wr_ready_s;
    assign wr_count = wr_count_r;
    assign pb_busy  = (state_r == ST_RUN);
    assign pb_done  = pb_done_r;
    assign err_o    = err_r;

endmodule

// File: tb/tb_fm_sb_playback.sv
// Self-checking bench for fm_sb_playback (SB_DW=64, DEPTH=16): a word-level
// reference model is compared every cycle, plus directed literal checks.
module tb_fm_sb_playback;
    import fm_sb_pkg::*;

    localparam int SB_DW  = 64;
    localparam int AXI_DW = 32;
    localparam int DEPTH  = 16;
    localparam int BEATS  = SB_DW / AXI_DW;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  pb_mode = 2'b00;
    logic        pb_start = 1'b0;
    logic        pb_hold = 1'b0;
    logic        wr_clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        wr_ready;
    logic [4:0]  wr_count;
    fm_rt        fm_o;
    logic        pb_busy;
    logic        pb_done;
    logic [2:0]  err_o;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fm_sb_playback #(
        .SB_DW(SB_DW), .AXI_DW(AXI_DW), .DEPTH(DEPTH), .PB_MODE_W(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb_mode(pb_mode), .pb_start(pb_start),
        .pb_hold(pb_hold), .wr_clr(wr_clr), .wr_en(wr_en), .wr_data(wr_data),
        .wr_ready(wr_ready), .wr_count(wr_count), .fm_o(fm_o), .pb_busy(pb_busy),
        .pb_done(pb_done), .err_o(err_o)
    );

    // Reference model: a list of stored words, a play index and the word due next cycle.
    logic [SB_DW-1:0] m_mem [DEPTH];
    logic [SB_DW-1:0] m_part = 64'h0;
    logic [SB_DW-1:0] m_data = 64'h0;
    int               m_count = 0, m_beat = 0, m_idx = 0;
    logic             m_run = 1'b0, m_vld = 1'b0, m_done = 1'b0;
    logic [2:0]       m_err = 3'b000;

    always @(posedge clk) begin : model
        logic nvld, ndone, ready, mode_ok;
        logic [SB_DW-1:0] ndata;
        if (!rst_n) begin
            m_count = 0; m_beat = 0; m_idx = 0; m_run = 1'b0;
            m_vld = 1'b0; m_done = 1'b0; m_data = 64'h0; m_err = 3'b000;
        end else begin
            ready   = !m_run && (m_count < DEPTH);
            mode_ok = (pb_mode == 2'b01) || (pb_mode == 2'b10);
            nvld = 1'b0; ndone = 1'b0; ndata = m_data;
            if (m_run) begin
                if (pb_mode == 2'b11) m_err[2] = 1'b1;
                if (!mode_ok || m_count == 0) begin
                    m_run = 1'b0;
                end else if (!pb_hold) begin
                    ndata = m_mem[m_idx];
                    nvld  = 1'b1;
                    if (m_idx == m_count - 1) begin
                        m_idx = 0;
                        if (pb_mode == 2'b01) begin
                            m_run = 1'b0;
                            ndone = 1'b1;
                        end
                    end else begin
                        m_idx = m_idx + 1;
                    end
                end
            end else if (pb_start) begin
                if (m_count == 0) m_err[1] = 1'b1;
                if (pb_mode == 2'b11) m_err[2] = 1'b1;
                if (mode_ok && m_count > 0) begin
                    m_run = 1'b1;
                    m_idx = 0;
                end
            end
            if (wr_clr) begin
                m_count = 0; m_beat = 0; m_err = 3'b000;
            end else if (wr_en) begin
                if (!ready) begin
                    m_err[0] = 1'b1;
                end else begin
                    m_part[m_beat*AXI_DW +: AXI_DW] = wr_data;
                    m_beat = m_beat + 1;
                    if (m_beat == BEATS) begin
                        m_mem[m_count] = m_part;
                        m_count = m_count + 1;
                        m_beat = 0;
                    end
                end
            end
            m_vld = nvld; m_done = ndone; m_data = ndata;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("fm_vld", 64'(fm_o.fm_vld), 64'(m_vld));
        chk("fm_data", fm_o.fm_data[63:0], m_data);
        chk("fm_data_ext", 64'(fm_o.fm_data[255:64] != 192'h0), 64'd0);
        chk("pb_done", 64'(pb_done), 64'(m_done));
        chk("pb_busy", 64'(pb_busy), 64'(m_run));
        chk("wr_count", 64'(wr_count), 64'(m_count));
        chk("wr_ready", 64'(wr_ready), 64'(!m_run && (m_count < DEPTH)));
        chk("err_o", 64'(err_o), 64'(m_err));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic wr_beat(input logic [31:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wr_word(input logic [63:0] w);
        wr_beat(w[31:0]);
        wr_beat(w[63:32]);
    endtask

    task automatic clear();
        wr_clr = 1'b1;
        tick();
        wr_clr = 1'b0;
    endtask

    task automatic start(input logic [1:0] mode);
        pb_mode = mode; pb_start = 1'b1;
        tick();
        pb_start = 1'b0;
    endtask

    task automatic wait_vld(output int lat);
        lat = 1;
        while (!fm_o.fm_vld && lat < 20) begin
            tick();
            lat++;
        end
        if (!fm_o.fm_vld) chk("vld_timeout", 64'd0, 64'd1);
    endtask

    logic [63:0] w [4];
    int lat, gone, zeros, e;
    logic seen;

    initial begin
        repeat (3) tick();
        chk("rst_wr_ready", 64'(wr_ready), 64'd1);
        chk("rst_fm_vld", 64'(fm_o.fm_vld), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        rst_n = 1'b1;
        tick();

        // Single word, single pass.
        wr_beat(32'h1111_1111);
        wr_beat(32'h2222_2222);
        chk("s1_wr_count", 64'(wr_count), 64'd1);
        start(2'b01);
        wait_vld(lat);
        chk("s1_latency", 64'(lat), 64'd2);
        chk("s1_data", fm_o.fm_data[63:0], 64'h2222_2222_1111_1111);
        chk("s1_done", 64'(pb_done), 64'd1);
        tick();
        chk("s1_vld_once", 64'(fm_o.fm_vld), 64'd0);
        chk("s1_idle", 64'(pb_busy), 64'd0);

        // Four words looping, then stop via mode 00.
        clear();
        for (int i = 0; i < 4; i++) begin
            w[i] = {$urandom, $urandom};
            wr_word(w[i]);
        end
        start(2'b10);
        wait_vld(lat);
        chk("s2_latency", 64'(lat), 64'd2);
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("s2_vld", 64'(fm_o.fm_vld), 64'd1);
            chk("s2_word", fm_o.fm_data[63:0], w[k % 4]);
            seen = seen | pb_done;
            tick();
        end
        pb_mode = 2'b00;
        gone = 0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            seen = seen | pb_done;
            if (!fm_o.fm_vld && gone == 0) gone = k;
        end
        chk("s2_stop_within2", 64'((gone >= 1) && (gone <= 2)), 64'd1);
        chk("s2_no_done", 64'(seen), 64'd0);

        // Hold for three cycles mid-run.
        start(2'b10);
        wait_vld(lat);
        zeros = 0; e = 0;
        for (int k = 0; k < 12; k++) begin
            pb_hold = (k >= 3 && k <= 5);
            if (fm_o.fm_vld) begin
                chk("s3_order", fm_o.fm_data[63:0], w[e % 4]);
                e++;
            end else begin
                zeros++;
            end
            tick();
        end
        pb_hold = 1'b0;
        chk("s3_bubbles", 64'(zeros), 64'd3);
        chk("s3_words", 64'(e), 64'd9);
        pb_mode = 2'b00;
        repeat (3) tick();

        // Overflow on a full store, then clear.
        clear();
        for (int i = 0; i < DEPTH * BEATS; i++) wr_beat($urandom);
        chk("s4_full_count", 64'(wr_count), 64'(DEPTH));
        chk("s4_full_ready", 64'(wr_ready), 64'd0);
        wr_beat(32'hDEAD_BEEF);
        chk("s4_ovf_err", 64'(err_o), 64'b001);
        chk("s4_ovf_count", 64'(wr_count), 64'(DEPTH));
        clear();
        chk("s4_clr_err", 64'(err_o), 64'd0);
        chk("s4_clr_count", 64'(wr_count), 64'd0);

        // Start while empty, then reserved mode.
        start(2'b01);
        chk("s5_empty_err", 64'(err_o), 64'b010);
        chk("s5_empty_busy", 64'(pb_busy), 64'd0);
        wr_word({$urandom, $urandom});
        start(2'b11);
        chk("s5_rsvd_err", 64'(err_o), 64'b110);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            seen = seen | fm_o.fm_vld;
        end
        chk("s5_rsvd_no_vld", 64'(seen), 64'd0);
        clear();

        // Reset during loop playback, then reload and replay.
        for (int i = 0; i < 4; i++) wr_word({$urandom, $urandom});
        start(2'b10);
        wait_vld(lat);
        repeat (3) tick();
        rst_n = 1'b0;
        tick();
        chk("s6_rst_vld", 64'(fm_o.fm_vld), 64'd0);
        chk("s6_rst_busy", 64'(pb_busy), 64'd0);
        chk("s6_rst_count", 64'(wr_count), 64'd0);
        rst_n = 1'b1;
        w[0] = 64'hA5A5_0F0F_1234_5678;
        wr_word(w[0]);
        start(2'b01);
        wait_vld(lat);
        chk("s6_latency", 64'(lat), 64'd2);
        chk("s6_data", fm_o.fm_data[63:0], w[0]);
        chk("s6_done", 64'(pb_done), 64'd1);
        tick();

        // Randomised traffic against the model.
        pb_mode = 2'b01;
        for (int c = 0; c < 600; c++) begin
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_data  = $urandom;
            wr_clr   = ($urandom_range(0, 80) == 0);
            pb_start = ($urandom_range(0, 12) == 0);
            pb_hold  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 24) == 0) pb_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 24) == 0) pb_mode = 2'($urandom_range(1, 2));
            tick();
        end
        wr_en = 1'b0; wr_clr = 1'b0; pb_start = 1'b0; pb_hold = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
